sram_uart_tx: RTL and testbench

SRAM_UART_TX -- requirements
Module: sram_uart_tx

---
 rtl/sram_uart_tx_pkg.sv | 18 +
 rtl/sram_uart_tx_byte.sv | 72 +++++++
 rtl/sram_uart_tx.sv | 152 +++++++++++++++
 tb/tb_sram_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_uart_tx_pkg.sv
// Shared types and constants for the SRAM-to-UART streaming master.
// The state type lives here so the top-level mux can name the states too.
package sram_uart_tx_pkg;

  localparam int ADDR_W     = 18;
  localparam int WORD_W     = 16;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_FETCH,
    S_TX_WAIT,
    S_TX_HIGH,
    S_TX_LOW,
    S_TX_DONE
  } tx_state_type;

endpackage

// File: rtl/sram_uart_tx_byte.sv
// 8N1 byte serializer: owns all bit timing. A load accepted in the last
// cycle of a stop bit starts the next frame with no idle cycle in between.
module uart_tx_byte
  import sram_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       frame_end,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  logic                  active_q, active_d;
  logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  bit_end;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    bit_end   = active_q && (clk_cnt_q == CNT_LAST);
    frame_end = bit_end && (bit_cnt_q == BIT_LAST);
    ready     = !active_q || frame_end;
    active_d  = active_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (load && ready) begin
      active_d  = 1'b1;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      shift_d   = {1'b1, data, 1'b0};
    end else if (frame_end) begin
      active_d  = 1'b0;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      shift_d   = '1;
    end else if (bit_end) begin
      clk_cnt_d = '0;
      bit_cnt_d = bit_cnt_q + 4'd1;
      shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
    end else if (active_q) begin
      clk_cnt_d = clk_cnt_q + 1'b1;
    end
  end

  // NOTE: flops use non-blocking assignments; the idle shift value of all ones keeps the line high.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      active_q  <= 1'b0;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '1;
    end else begin
      active_q  <= active_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  assign tx = shift_q[0];

endmodule

// File: rtl/sram_uart_tx.sv
// Streams word_count SRAM words out of the UART, high byte first, with the
// next word prefetched during the low-byte frame so frames run back-to-back.
module sram_uart_tx
  import sram_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int READ_LATENCY = 2
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        start,
  input  logic [17:0] base_address,
  input  logic [17:0] word_count,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX_O,
  output logic        busy,
  output logic        done
);

  localparam int WAIT_W = $clog2(READ_LATENCY + 1) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST     = WAIT_W'(READ_LATENCY - 1);
  localparam logic [WAIT_W-1:0] PREFETCH_LAST = WAIT_W'(READ_LATENCY);

  tx_state_type        state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   words_left_q, words_left_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                prefetch_q, prefetch_d;
  logic                tx_load;
  logic [7:0]          tx_data;
  logic                tx_ready;
  logic                tx_frame_end;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .CLOCK_50_I(CLOCK_50_I),
    .resetn    (resetn),
    .load      (tx_load),
    .data      (tx_data),
    .ready     (tx_ready),
    .frame_end (tx_frame_end),
    .tx        (UART_TX_O)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    word_d       = word_q;
    wait_cnt_d   = wait_cnt_q;
    prefetch_d   = prefetch_q;
    tx_load      = 1'b0;
    tx_data      = word_q[15:8];
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_TX_IDLE: begin
        if (start) begin
          words_left_d = word_count;
          if (word_count == '0) begin
            state_d = S_TX_DONE;
          end else begin
            addr_d     = base_address;
            wait_cnt_d = '0;
            state_d    = S_TX_FETCH;
          end
        end
      end
      S_TX_FETCH: begin
        busy    = 1'b1;
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        busy = 1'b1;
        if ((wait_cnt_q == WAIT_LAST) && tx_ready) begin
          word_d  = SRAM_read_data;
          tx_load = 1'b1;
          tx_data = SRAM_read_data[15:8];
          state_d = S_TX_HIGH;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_TX_HIGH: begin
        busy = 1'b1;
        if (tx_frame_end) begin
          tx_load      = 1'b1;
          tx_data      = word_q[7:0];
          words_left_d = words_left_q - 18'd1;
          state_d      = S_TX_LOW;
          // Launch the next read now; the word is latched well before this frame ends.
          if (words_left_q != 18'd1) begin
            addr_d     = addr_q + 18'd1;
            wait_cnt_d = '0;
            prefetch_d = 1'b1;
          end
        end
      end
      S_TX_LOW: begin
        busy = 1'b1;
        if (prefetch_q) begin
          if (wait_cnt_q == PREFETCH_LAST) begin
            word_d     = SRAM_read_data;
            prefetch_d = 1'b0;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        if (tx_frame_end) begin
          if (words_left_q != '0) begin
            tx_load = 1'b1;
            tx_data = word_q[15:8];
            state_d = S_TX_HIGH;
          end else begin
            state_d = S_TX_DONE;
          end
        end
      end
      S_TX_DONE: begin
        done    = 1'b1;
        state_d = S_TX_IDLE;
      end
      default: state_d = S_TX_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_TX_IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
      word_q       <= '0;
      wait_cnt_q   <= '0;
      prefetch_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      word_q       <= word_d;
      wait_cnt_q   <= wait_cnt_d;
      prefetch_q   <= prefetch_d;
    end
  end

  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;

endmodule

// File: tb/tb_sram_uart_tx.sv
// Directed bench for sram_uart_tx: a latency-accurate SRAM model feeds the
// DUT and every line cycle is compared against hand-computed 8N1 frames.
`timescale 1ns/1ps
module tb_sram_uart_tx;

  localparam int CPB = 434;
  localparam int RL  = 2;

  logic        CLOCK_50_I = 1'b0;
  logic        resetn     = 1'b1;
  logic        start      = 1'b0;
  logic [17:0] base_address = '0;
  logic [17:0] word_count   = '0;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        UART_TX_O;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [logic [17:0]];
  logic [15:0] rd_pipe [RL];

  sram_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .READ_LATENCY(RL)
  ) dut (
    .CLOCK_50_I    (CLOCK_50_I),
    .resetn        (resetn),
    .start         (start),
    .base_address  (base_address),
    .word_count    (word_count),
    .SRAM_address  (SRAM_address),
    .SRAM_we_n     (SRAM_we_n),
    .SRAM_read_data(SRAM_read_data),
    .UART_TX_O     (UART_TX_O),
    .busy          (busy),
    .done          (done)
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  // Data for the address seen at an edge appears RL edges later.
  always @(posedge CLOCK_50_I) begin
    rd_pipe[0] <= mem.exists(SRAM_address) ? mem[SRAM_address] : 16'hDEAD;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign SRAM_read_data = rd_pipe[RL-1];

  task automatic pulse_start(input logic [17:0] base, input logic [17:0] count);
    @(negedge CLOCK_50_I);
    base_address = base;
    word_count   = count;
    start        = 1'b1;
    @(negedge CLOCK_50_I);
    start = 1'b0;
  endtask

  task automatic wait_first_start(input string name);
    int n = 1;
    while (UART_TX_O !== 1'b0 && n < RL + 4) begin
      @(negedge CLOCK_50_I);
      n++;
    end
    n_cmp++;
    if (UART_TX_O !== 1'b0 || n > RL + 2) begin
      n_bad++;
      $display("FAIL %s first_start: line=%b after %0d cycles, required 0 within %0d", name, UART_TX_O, n, RL + 2);
    end
  endtask

  task automatic expect_frame(input logic [7:0] b, input string name);
    logic [9:0] frame;
    logic       exp_bit;
    logic       got;
    logic       bad;
    int         where;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      exp_bit = frame[i];
      bad     = 1'b0;
      got     = exp_bit;
      where   = 0;
      for (int c = 0; c < CPB; c++) begin
        if (!bad && UART_TX_O !== exp_bit) begin
          bad   = 1'b1;
          got   = UART_TX_O;
          where = c;
        end
        @(negedge CLOCK_50_I);
      end
      n_cmp++;
      if (bad) begin
        n_bad++;
        $display("FAIL %s byte %h bit%0d: line=%b at cycle %0d of bit, required %b", name, b, i, got, where, exp_bit);
      end
    end
  endtask

  task automatic expect_done(input string name);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_pulse: done=%b busy=%b, required done=1 busy=0", name, done, busy);
    end
    @(negedge CLOCK_50_I);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_width: done=%b, required 0", name, done);
    end
  endtask

  task automatic test_reset();
    #5 resetn = 1'b0;
    repeat (2) @(negedge CLOCK_50_I);
    n_cmp++;
    if (UART_TX_O !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: tx=%b busy=%b done=%b, required 1 0 0", UART_TX_O, busy, done);
    end
    n_cmp++;
    if (SRAM_address !== 18'h0 || SRAM_we_n !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_sram: addr=%h we_n=%b, required 00000 1", SRAM_address, SRAM_we_n);
    end
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50_I);
  endtask

  task automatic test_empty();
    logic bad = 1'b0;
    pulse_start(18'h00555, 18'd0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_done: done=%b busy=%b, required 1 0", done, busy);
    end
    @(negedge CLOCK_50_I);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_done_width: done=%b, required 0", done);
    end
    for (int c = 0; c < 12; c++) begin
      if (UART_TX_O !== 1'b1 || SRAM_address !== 18'h0) bad = 1'b1;
      @(negedge CLOCK_50_I);
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL empty_quiet: line or address moved (tx=%b addr=%h), required tx=1 addr=00000", UART_TX_O, SRAM_address);
    end
  endtask

  task automatic test_single_word();
    pulse_start(18'h0, 18'd1);
    wait_first_start("single");
    expect_frame(8'hA5, "single");
    expect_frame(8'h5A, "single");
    expect_done("single");
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [4];
    words = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    pulse_start(18'd100, 18'd4);
    wait_first_start("b2b");
    for (int w = 0; w < 4; w++) begin
      expect_frame(words[w][15:8], "b2b");
      expect_frame(words[w][7:0], "b2b");
    end
    expect_done("b2b");
    n_cmp++;
    if (SRAM_address !== 18'd103) begin
      n_bad++;
      $display("FAIL b2b_last_addr: addr=%h, required %h", SRAM_address, 18'd103);
    end
  endtask

  task automatic test_wrap();
    pulse_start(18'h3FFFF, 18'd2);
    wait_first_start("wrap");
    n_cmp++;
    if (SRAM_address !== 18'h3FFFF) begin
      n_bad++;
      $display("FAIL wrap_first_addr: addr=%h, required 3ffff", SRAM_address);
    end
    expect_frame(8'h1E, "wrap");
    expect_frame(8'h2D, "wrap");
    expect_frame(8'hA5, "wrap");
    expect_frame(8'h5A, "wrap");
    expect_done("wrap");
    n_cmp++;
    if (SRAM_address !== 18'h0) begin
      n_bad++;
      $display("FAIL wrap_second_addr: addr=%h, required 00000", SRAM_address);
    end
  endtask

  task automatic test_busy_guard();
    logic bad = 1'b0;
    pulse_start(18'd10, 18'd1);
    fork
      begin
        wait_first_start("guard");
        expect_frame(8'hC3, "guard");
        expect_frame(8'h3C, "guard");
        expect_done("guard");
        for (int c = 0; c < 20; c++) begin
          if (done !== 1'b0 || UART_TX_O !== 1'b1 || busy !== 1'b0) bad = 1'b1;
          @(negedge CLOCK_50_I);
        end
        n_cmp++;
        if (bad) begin
          n_bad++;
          $display("FAIL guard_after: extra activity (done=%b tx=%b busy=%b), required idle", done, UART_TX_O, busy);
        end
      end
      begin
        repeat (1000) @(negedge CLOCK_50_I);
        base_address = 18'd20;
        word_count   = 18'd3;
        start        = 1'b1;
        @(negedge CLOCK_50_I);
        start = 1'b0;
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    logic bad = 1'b0;
    pulse_start(18'd30, 18'd1);
    wait_first_start("midrst");
    repeat (CPB * 3) @(negedge CLOCK_50_I);
    n_cmp++;
    if (UART_TX_O !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_data_bit: line=%b, required 0", UART_TX_O);
    end
    #3 resetn = 1'b0;
    #1;
    n_cmp++;
    if (UART_TX_O !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || SRAM_address !== 18'h0) begin
      n_bad++;
      $display("FAIL midrst_immediate: tx=%b busy=%b done=%b addr=%h, required 1 0 0 00000", UART_TX_O, busy, done, SRAM_address);
    end
    @(negedge CLOCK_50_I);
    resetn = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (UART_TX_O !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      @(negedge CLOCK_50_I);
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL midrst_no_resume: tx=%b busy=%b, required idle", UART_TX_O, busy);
    end
    pulse_start(18'd31, 18'd1);
    wait_first_start("midrst");
    expect_frame(8'h3C, "midrst");
    expect_frame(8'h81, "midrst");
    expect_done("midrst");
  endtask

  initial begin
    mem[18'd0]     = 16'hA55A;
    mem[18'd10]    = 16'hC33C;
    mem[18'd20]    = 16'hFFFF;
    mem[18'd21]    = 16'hFFFF;
    mem[18'd22]    = 16'hFFFF;
    mem[18'd30]    = 16'h0000;
    mem[18'd31]    = 16'h3C81;
    mem[18'd100]   = 16'h0123;
    mem[18'd101]   = 16'h4567;
    mem[18'd102]   = 16'h89AB;
    mem[18'd103]   = 16'hCDEF;
    mem[18'h3FFFF] = 16'h1E2D;

    test_reset();
    test_empty();
    test_single_word();
    test_back_to_back();
    test_wrap();
    test_busy_guard();
    test_reset_mid_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
